// File: rtl/tt_pkg.sv
// tt_pkg: shared types and sizes for the tt_sweep truth-table sweeper.
//   tt_state_e : sweep FSM states (IDLE -> RUN -> FIN -> IDLE)
//   VEC_N      : number of input vectors of the 4-input function
//   IDX_W      : width of the vector index
//   SIG_W      : width of the captured truth-table signature
package tt_pkg;

  localparam int VEC_N = 16;
  localparam int IDX_W = 4;
  localparam int SIG_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } tt_state_e;

endpackage

// File: rtl/tt_dwell_cnt.sv
// tt_dwell_cnt: load/decrement hold counter for one sweep vector.
//   clk, rst_n : clock, asynchronous active-low reset (count resets to 0)
//   load_i     : reload the count to DWELL-1 (has priority over dec_i)
//   dec_i      : decrement by one; holds at zero
//   zero_o     : count is zero, i.e. this is the last cycle of the hold
module tt_dwell_cnt #(
  parameter int DWELL = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);

  localparam int CW = $clog2(DWELL + 1);
  localparam logic [CW-1:0] RELOAD = CW'(DWELL - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = RELOAD;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/tt_sweep.sv
// tt_sweep: drives A,B,C,D through all 16 vectors in ascending order, holds
// each for DWELL cycles, samples f on the last cycle of each hold into sig,
// then compares sig against EXP and reports pass with a one-cycle done.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : begin a sweep (only honoured in IDLE)
//   f            : output of the function under test
//   A,B,C,D      : applied vector, {A,B,C,D} == idx, A is the MSB
//   idx          : current vector index
//   busy         : sweep in progress
//   done         : one-cycle pulse after the final sample
//   pass         : sig == EXP, valid from done until the next start
//   sig          : captured truth table, bit i = f for vector i
//   err_cnt      : (TT_SWEEP_ERRCNT_EN only) number of vectors where f != EXP[i]
//   state_dbg    : current FSM state, for observation only
// Optional feature macro: TT_SWEEP_ERRCNT_EN.
// There is no streaming handshake: start is a level sampled in IDLE only, and
// done is a single-cycle strobe with no back-pressure.
module tt_sweep
  import tt_pkg::*;
#(
  parameter int               DWELL = 20,
  parameter logic [SIG_W-1:0] EXP   = 16'h0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             f,
  output logic             A,
  output logic             B,
  output logic             C,
  output logic             D,
  output logic [IDX_W-1:0] idx,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] sig,
`ifdef TT_SWEEP_ERRCNT_EN
  output logic [4:0]       err_cnt,
`endif
  output tt_state_e        state_dbg
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_N - 1);

  tt_state_e        state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic             pass_q, pass_d;
  logic             cnt_load, cnt_dec, cnt_zero;
`ifdef TT_SWEEP_ERRCNT_EN
  logic [4:0]       errc_q, errc_d;
`endif

  tt_dwell_cnt #(.DWELL(DWELL)) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (cnt_load),
    .dec_i  (cnt_dec),
    .zero_o (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sig_d    = sig_q;
    pass_d   = pass_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
`ifdef TT_SWEEP_ERRCNT_EN
    errc_d   = errc_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_RUN;
          idx_d    = '0;
          sig_d    = '0;
          pass_d   = 1'b0;
          cnt_load = 1'b1;
`ifdef TT_SWEEP_ERRCNT_EN
          errc_d   = '0;
`endif
        end
      end
      ST_RUN: begin
        if (cnt_zero) begin
          // Last cycle of this vector's hold: capture f.
          sig_d[idx_q] = f;
`ifdef TT_SWEEP_ERRCNT_EN
          if (f != EXP[idx_q]) errc_d = errc_q + 5'd1;
`endif
          if (idx_q != LAST_IDX) begin
            idx_d    = idx_q + 1'b1;
            cnt_load = 1'b1;
          end else begin
            // Compare with the signature including bit 15 so pass is
            // visible in the same cycle as done.
            state_d = ST_FIN;
            pass_d  = (sig_d == EXP);
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      sig_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sig_q   <= sig_d;
      pass_q  <= pass_d;
    end
  end

`ifdef TT_SWEEP_ERRCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      errc_q <= '0;
    end else begin
      errc_q <= errc_d;
    end
  end

  assign err_cnt = errc_q;
`endif

  assign {A, B, C, D} = idx_q;
  assign idx          = idx_q;
  assign busy         = (state_q == ST_RUN);
  assign done         = (state_q == ST_FIN);
  assign pass         = pass_q;
  assign sig          = sig_q;
  assign state_dbg    = state_q;

endmodule
